// File: rtl/axis_s2mem_pkg.sv
// Shared widths and FSM state encoding for the AXI-Stream to FFT-memory loader.
// ADDR_WIDTH must satisfy FFT_SIZE == 2**ADDR_WIDTH; DATA_WIDTH holds {re, im}.
package axis_s2mem_pkg;

    localparam int ADDR_WIDTH = 12;
    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_FILL = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/axis_s2mem_addr_bitrev.sv
// Combinational bit-reversal of an ADDR_WIDTH address, used for in-place DIT loading.
// Present only when S2MEM_BITREV_EN is defined; the natural-order build has no use for it.
`ifdef S2MEM_BITREV_EN
module addr_bitrev
    import axis_s2mem_pkg::*;
(
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic [ADDR_WIDTH-1:0] addr_o
);

    for (genvar i = 0; i < ADDR_WIDTH; i++) begin : g_rev
        assign addr_o[i] = addr_i[ADDR_WIDTH-1-i];
    end

endmodule
`endif

// File: rtl/axis_s2mem.sv
// AXI4-Stream slave that writes one real frame of FFT_SIZE samples into FFT bank 0 as {re, 0}.
// Define S2MEM_BITREV_EN to write at bit-reversed addresses; default build writes natural order.
module axis_s2mem
    import axis_s2mem_pkg::*;
#(
    parameter int FFT_SIZE     = 4096,
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rx_start,
    input  logic [SAMPLE_WIDTH-1:0] s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    output logic                    axis_rx,
    output logic                    axis_s2mem_we,
    output logic [ADDR_WIDTH-1:0]   axis_s2mem_waddr,
    output logic [DATA_WIDTH-1:0]   axis_s2mem_wdata,
    output logic                    rx_done,
    output logic                    rx_err,
    output logic [1:0]              dbg_state_o
);

    localparam int CW   = ADDR_WIDTH + 1;
    localparam int HALF = DATA_WIDTH / 2;
    localparam logic [CW-1:0] LAST_IDX = CW'(FFT_SIZE - 1);

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    axis_rx_q;

    logic                    handshake;
    logic [ADDR_WIDTH-1:0]   cnt_addr;
    logic signed [SAMPLE_WIDTH-1:0] sample_s;
    logic [HALF-1:0]         sample_re;

    // Valid/ready: a beat transfers on a rising edge where tvalid and tready are both high;
    // tready depends only on the registered state, never on tvalid.
    assign handshake = s_axis_tvalid & (state_q == ST_RECV);

    assign sample_s  = s_axis_tdata;
    assign sample_re = HALF'(sample_s);

`ifdef S2MEM_BITREV_EN
    addr_bitrev u_addr_bitrev (
        .addr_i (cnt_q[ADDR_WIDTH-1:0]),
        .addr_o (cnt_addr)
    );
`else
    assign cnt_addr = cnt_q[ADDR_WIDTH-1:0];
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (rx_start) begin
                    state_d = ST_RECV;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            ST_RECV: begin
                if (handshake) begin
                    we_d    = 1'b1;
                    waddr_d = cnt_addr;
                    wdata_d = {sample_re, HALF'(0)};
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_DONE;
                        if (!s_axis_tlast) err_d = 1'b1;
                    end else if (s_axis_tlast) begin
                        // Short frame: pad the rest of the bank with zeros.
                        state_d = ST_FILL;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_FILL: begin
                we_d    = 1'b1;
                waddr_d = cnt_addr;
                wdata_d = '0;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_IDX) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            axis_rx_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            // Registered off the next state so ownership spans the final write in DONE.
            axis_rx_q <= (state_d != ST_IDLE);
        end
    end

    assign s_axis_tready    = (state_q == ST_RECV);
    assign rx_done          = (state_q == ST_DONE);
    assign rx_err           = err_q;
    assign axis_rx          = axis_rx_q;
    assign axis_s2mem_we    = we_q;
    assign axis_s2mem_waddr = waddr_q;
    assign axis_s2mem_wdata = wdata_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_axis_s2mem.sv
// Self-checking bench for axis_s2mem: frame-level reference model, per-cycle compare process.
// Honours S2MEM_BITREV_EN to predict bit-reversed write addresses.
module tb_axis_s2mem;
  import axis_s2mem_pkg::*;

  localparam int N  = 4096;
  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          rx_start = 1'b0;
  logic [15:0]   s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic          axis_rx;
  logic          axis_s2mem_we;
  logic [AW-1:0] axis_s2mem_waddr;
  logic [DW-1:0] axis_s2mem_wdata;
  logic          rx_done;
  logic          rx_err;
  logic [1:0]    dbg_state;

  axis_s2mem #(.FFT_SIZE(N), .SAMPLE_WIDTH(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .rx_start         (rx_start),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .s_axis_tlast     (s_axis_tlast),
    .axis_rx          (axis_rx),
    .axis_s2mem_we    (axis_s2mem_we),
    .axis_s2mem_waddr (axis_s2mem_waddr),
    .axis_s2mem_wdata (axis_s2mem_wdata),
    .rx_done          (rx_done),
    .rx_err           (rx_err),
    .dbg_state_o      (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [AW+DW-1:0] exp_q[$];
  logic [AW-1:0] log_addr [N];
  logic [DW-1:0] log_data [N];
  int  wr_idx = 0;
  int  done_cnt = 0;
  bit  done_armed = 0;
  bit  done_prev = 0;
  bit  exp_err = 0;
  bit  model_recv = 0;
  logic [AW+DW-1:0] e;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [AW-1:0] exp_addr(input int k);
`ifdef S2MEM_BITREV_EN
    int r;
    r = 0;
    for (int i = 0; i < AW; i++) r = r * 2 + ((k >> i) & 1);
    return AW'(r);
`else
    return AW'(k);
`endif
  endfunction

  function automatic logic [DW-1:0] exp_word(input logic [15:0] s);
    int v;
    logic [DW/2-1:0] re;
    v  = int'($signed(s));
    re = v[DW/2-1:0];
    return {re, 16'h0000};
  endfunction

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("tready", s_axis_tready, model_recv);
        if (done_prev) begin
          check("axis_rx_low_after_done", axis_rx, 0);
          check("no_write_after_done", axis_s2mem_we, 0);
        end
        done_prev = rx_done;
        if (axis_s2mem_we) begin
          check("axis_rx_during_write", axis_rx, 1);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected no write", axis_s2mem_waddr, axis_s2mem_wdata);
          end else begin
            e = exp_q.pop_front();
            check("waddr", axis_s2mem_waddr, e[AW+DW-1:DW]);
            check("wdata", axis_s2mem_wdata, e[DW-1:0]);
          end
          if (wr_idx < N) begin
            log_addr[wr_idx] = axis_s2mem_waddr;
            log_data[wr_idx] = axis_s2mem_wdata;
          end
          wr_idx++;
        end
        if (rx_done) begin
          check("rx_done_expected", done_armed, 1);
          check("writes_pending_at_done", exp_q.size(), 0);
          check("rx_err_at_done", rx_err, exp_err);
          check("axis_rx_at_done", axis_rx, 1);
          done_armed = 0;
          done_cnt++;
        end
      end
    end
  end

  // ---------------- driver tasks (entered #1 after a rising edge) ----------------
  task automatic start_rx();
    rx_start = 1'b1;
    @(posedge clk); #1;
    rx_start = 1'b0;
    model_recv = 1;
    wr_idx = 0;
    check("rx_err_cleared_on_start", rx_err, 0);
    check("axis_rx_rise", axis_rx, 1);
  endtask

  task automatic send_beat(input logic [15:0] d, input bit last, input bit gaps, output bit ok);
    bit acc;
    if (gaps) begin
      while ($urandom_range(0, 1) == 0) begin
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 16'($urandom);
        s_axis_tlast  = 1'($urandom);
        @(posedge clk); #1;
      end
    end
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    ok = 0;
    for (int c = 0; c < 100; c++) begin
      acc = s_axis_tready;
      @(posedge clk); #1;
      if (acc) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL beat_accept_timeout: got no handshake expected handshake within 100 cycles");
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_done(input int start_cnt);
    for (int c = 0; c < 6000 && done_cnt == start_cnt; c++) begin
      @(posedge clk); #1;
    end
    check("rx_done_seen", done_cnt - start_cnt, 1);
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("rx_done_once", done_cnt - start_cnt, 1);
    check("rx_err_sticky", rx_err, exp_err);
    check("write_count", wr_idx, N);
    check("idle_after_frame", dbg_state, 2'd0);
  endtask

  // tlast_idx == N means the frame never carries tlast.
  task automatic run_frame(input bit ramp, input int tlast_idx, input bit gaps, input bit poke,
                           input int fix_idx, input logic [15:0] fix_val);
    int nb;
    int start_cnt;
    bit ok;
    logic [15:0] d;
    start_cnt = done_cnt;
    start_rx();
    nb = (tlast_idx < N) ? tlast_idx + 1 : N;
    for (int k = 0; k < nb; k++) begin
      d = ramp ? 16'(k) : 16'($urandom);
      if (k == fix_idx) d = fix_val;
      if (poke && k == 50) rx_start = 1'b1;
      send_beat(d, k == tlast_idx, gaps, ok);
      rx_start = 1'b0;
      if (!ok) return;
      exp_q.push_back({exp_addr(k), exp_word(d)});
    end
    model_recv = 0;
    for (int j = nb; j < N; j++) exp_q.push_back({exp_addr(j), {DW{1'b0}}});
    exp_err = (tlast_idx != N - 1);
    done_armed = 1;
    if (tlast_idx < N - 1) begin
      // Beats offered after a short frame must stay on the bus.
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 16'h1234;
      s_axis_tlast  = 1'b1;
    end
    wait_done(start_cnt);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tready"}, s_axis_tready, 0);
    check({tag, "_axis_rx"}, axis_rx, 0);
    check({tag, "_we"}, axis_s2mem_we, 0);
    check({tag, "_waddr"}, axis_s2mem_waddr, 0);
    check({tag, "_wdata"}, axis_s2mem_wdata, 0);
    check({tag, "_rx_done"}, rx_done, 0);
    check({tag, "_rx_err"}, rx_err, 0);
    check({tag, "_state"}, dbg_state, 2'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int start_cnt;
    bit ok;
    logic [15:0] d;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full-rate ramp with tlast on the final sample.
    run_frame(1'b1, N - 1, 1'b0, 1'b0, -1, 16'h0);
    check("ramp_addr_4095", log_addr[4095], 12'hFFF);
    check("ramp_data_4095", log_data[4095], 32'h0FFF_0000);
    check("ramp_data_5", log_data[5], 32'h0005_0000);
`ifdef S2MEM_BITREV_EN
    check("bitrev_addr_idx1", log_addr[1], 12'd2048);
    check("bitrev_addr_idx3", log_addr[3], 12'd3072);
`else
    check("natural_addr_idx1", log_addr[1], 12'd1);
    check("natural_addr_idx3", log_addr[3], 12'd3);
`endif

    // Random gaps and data, most-negative sample at index 7, stray rx_start mid-frame.
    run_frame(1'b0, N - 1, 1'b1, 1'b1, 7, 16'h8000);
    check("neg_sample_word", log_data[7], 32'h8000_0000);

    // Early tlast on sample 99: zero fill of the rest.
    run_frame(1'b1, 99, 1'b0, 1'b0, -1, 16'h0);
    check("early_last_data_99", log_data[99], 32'h0063_0000);
    check("fill_data_100", log_data[100], 32'h0);
    check("fill_data_4095", log_data[4095], 32'h0);
`ifdef S2MEM_BITREV_EN
    check("fill_addr_100", log_addr[100], 12'd608);
`else
    check("fill_addr_100", log_addr[100], 12'd100);
`endif

    // tlast one sample early: exactly one fill word.
    run_frame(1'b0, N - 2, 1'b0, 1'b0, -1, 16'h0);

    // Missing tlast on the final sample still commits the frame.
    run_frame(1'b0, N, 1'b0, 1'b0, -1, 16'h0);

    // Asynchronous reset part-way through a frame.
    start_cnt = done_cnt;
    start_rx();
    for (int k = 0; k < 2000; k++) begin
      d = 16'($urandom);
      send_beat(d, 1'b0, 1'b0, ok);
      if (!ok) break;
      exp_q.push_back({exp_addr(k), exp_word(d)});
    end
    @(negedge clk); #1;
    rst_n = 1'b0;
    s_axis_tvalid = 1'b0;
    #1;
    check_reset_outputs("midframe_reset");
    exp_q.delete();
    model_recv = 0;
    done_armed = 0;
    done_prev = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("no_done_after_abort", done_cnt - start_cnt, 0);
    check("idle_after_abort", dbg_state, 2'd0);

    // Clean frame after the aborted one.
    run_frame(1'b0, N - 1, 1'b1, 1'b0, -1, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
